datapath_ctrl: RTL and testbench

- Instruction sequencer that drives the register-file/mux/ULA datapath.
- Accepts one instruction word per valid/ready handshake and decodes it into register selects, ULA operation, operand source and write strobe.
- Writes the ULA result (or an immediate) back through the datapath's external write-data input, then reports result and flags to the issuer.
- Sits between an instruction source (testbench or fetch unit) and the datapath.

---
 rtl/datapath_ctrl_pkg.sv | 43 ++++
 rtl/datapath_ctrl_if.sv | 40 ++++
 rtl/datapath_ctrl_decode.sv | 39 +++
 rtl/datapath_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_datapath_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_ctrl_pkg.sv
// Shared types and instruction-field layout for the datapath instruction sequencer.
// The low 14 bits of every instruction hold the header; the immediate sits above it.
package datapath_ctrl_pkg;

  localparam int unsigned OpLsb    = 0;
  localparam int unsigned RdLsb    = 3;
  localparam int unsigned Rs1Lsb   = 6;
  localparam int unsigned Rs2Lsb   = 9;
  localparam int unsigned KindLsb  = 12;
  localparam int unsigned ImmLsb   = 14;
  localparam int unsigned RegSelW  = 3;
  localparam int unsigned OpW      = 3;
  localparam int unsigned KindW    = 2;
  localparam int unsigned HdrWidth = ImmLsb;

  typedef enum logic [1:0] {
    KindAluRr = 2'b00,
    KindAluRi = 2'b01,
    KindLoadi = 2'b10,
    KindNop   = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StWb   = 2'b10,
    StDone = 2'b11
  } state_e;

  // Header only, so the struct does not depend on the datapath width.
  typedef struct packed {
    kind_e              kind;
    logic [RegSelW-1:0] rs2;
    logic [RegSelW-1:0] rs1;
    logic [RegSelW-1:0] rd;
    logic [OpW-1:0]     op;
  } instr_hdr_t;

  function automatic logic is_alu(input kind_e kind);
    return (kind == KindAluRr) || (kind == KindAluRi);
  endfunction

endpackage

// File: rtl/datapath_ctrl_if.sv
// Instruction handshake plus datapath control/status bundle for datapath_ctrl.
// master = sequencer side, slave = instruction source / datapath side.
interface datapath_ctrl_if #(
  parameter int unsigned DataWidth = 8
);
  localparam int unsigned InstrWidth = DataWidth + 14;

  logic [InstrWidth-1:0] instr;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DataWidth-1:0]  ULAResult;
  logic                  Flag_z;
  logic                  CarryOut;
  logic [DataWidth-1:0]  wd3;
  logic [2:0]            wa3;
  logic                  we3;
  logic [2:0]            ra1;
  logic [2:0]            ra2;
  logic [2:0]            ULAControl;
  logic                  select_src;
  logic [DataWidth-1:0]  constante;
  logic [DataWidth-1:0]  result;
  logic                  result_z;
  logic                  result_c;
  logic                  done;
  logic                  sticky_carry;

  modport master (
    input  instr, instr_valid, ULAResult, Flag_z, CarryOut,
    output instr_ready, wd3, wa3, we3, ra1, ra2, ULAControl, select_src, constante,
           result, result_z, result_c, done, sticky_carry
  );

  modport slave (
    output instr, instr_valid, ULAResult, Flag_z, CarryOut,
    input  instr_ready, wd3, wa3, we3, ra1, ra2, ULAControl, select_src, constante,
           result, result_z, result_c, done, sticky_carry
  );

endinterface

// File: rtl/datapath_ctrl_decode.sv
// Combinational field split of an instruction word: register selects, op, immediate,
// operand-source select and the state that follows acceptance.
module datapath_ctrl_decode
  import datapath_ctrl_pkg::*;
#(
  parameter int unsigned DataWidth = 8
) (
  input  logic [DataWidth+HdrWidth-1:0] instr_i,
  output logic [OpW-1:0]                op_o,
  output logic [RegSelW-1:0]            rd_o,
  output logic [RegSelW-1:0]            rs1_o,
  output logic [RegSelW-1:0]            rs2_o,
  output kind_e                         kind_o,
  output logic [DataWidth-1:0]          imm_o,
  output logic                          select_src_o,
  output logic                          is_alu_o,
  output state_e                        next_state_o
);

  instr_hdr_t hdr;

  always_comb begin
    hdr          = instr_hdr_t'(instr_i[HdrWidth-1:0]);
    op_o         = hdr.op;
    rd_o         = hdr.rd;
    rs1_o        = hdr.rs1;
    rs2_o        = hdr.rs2;
    kind_o       = hdr.kind;
    imm_o        = instr_i[ImmLsb +: DataWidth];
    select_src_o = (hdr.kind == KindAluRi);
    is_alu_o     = is_alu(hdr.kind);
    unique case (hdr.kind)
      KindAluRr, KindAluRi: next_state_o = StExec;
      KindLoadi:            next_state_o = StWb;
      default:              next_state_o = StDone;
    endcase
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Instruction sequencer for the register-file/mux/ULA datapath; all outputs registered.
// Optional sticky carry flag enabled by defining DPCTRL_STICKY_CARRY_EN.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int unsigned DataWidth = 8
) (
  input logic             clk,
  input logic             reset,
  datapath_ctrl_if.master bus
);

  localparam int unsigned InstrWidth = DataWidth + HdrWidth;

  state_e                  state_q, state_d;
  logic [InstrWidth-1:0]   instr_q, instr_d;
  logic                    instr_ready_q, instr_ready_d;
  logic [DataWidth-1:0]    wd3_q, wd3_d;
  logic [RegSelW-1:0]      wa3_q, wa3_d;
  logic                    we3_q, we3_d;
  logic [RegSelW-1:0]      ra1_q, ra1_d;
  logic [RegSelW-1:0]      ra2_q, ra2_d;
  logic [OpW-1:0]          ula_ctrl_q, ula_ctrl_d;
  logic                    select_src_q, select_src_d;
  logic [DataWidth-1:0]    constante_q, constante_d;
  logic [DataWidth-1:0]    result_q, result_d;
  logic                    result_z_q, result_z_d;
  logic                    result_c_q, result_c_d;
  logic                    done_q, done_d;
  logic                    sticky_q, sticky_d;

  logic                    accept;
  logic [InstrWidth-1:0]   dec_word;
  logic [OpW-1:0]          dec_op;
  logic [RegSelW-1:0]      dec_rd, dec_rs1, dec_rs2;
  kind_e                   dec_kind;
  logic [DataWidth-1:0]    dec_imm;
  logic                    dec_sel, dec_is_alu;
  state_e                  dec_next;

  assign accept   = bus.instr_valid & instr_ready_q;
  // In IDLE decode the offered word so the EXEC controls can be registered on accept.
  assign dec_word = (state_q == StIdle) ? bus.instr : instr_q;

  datapath_ctrl_decode #(
    .DataWidth(DataWidth)
  ) u_decode (
    .instr_i      (dec_word),
    .op_o         (dec_op),
    .rd_o         (dec_rd),
    .rs1_o        (dec_rs1),
    .rs2_o        (dec_rs2),
    .kind_o       (dec_kind),
    .imm_o        (dec_imm),
    .select_src_o (dec_sel),
    .is_alu_o     (dec_is_alu),
    .next_state_o (dec_next)
  );

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    wd3_d        = wd3_q;
    wa3_d        = wa3_q;
    we3_d        = 1'b0;
    ra1_d        = ra1_q;
    ra2_d        = ra2_q;
    ula_ctrl_d   = ula_ctrl_q;
    select_src_d = select_src_q;
    constante_d  = constante_q;
    result_d     = result_q;
    result_z_d   = result_z_q;
    result_c_d   = result_c_q;
    done_d       = 1'b0;
    sticky_d     = sticky_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          instr_d = bus.instr;
          state_d = dec_next;
          if (dec_is_alu) begin
            ra1_d        = dec_rs1;
            ra2_d        = dec_rs2;
            ula_ctrl_d   = dec_op;
            select_src_d = dec_sel;
            constante_d  = dec_imm;
          end
          if (dec_kind == KindLoadi) begin
            we3_d = 1'b1;
            wa3_d = dec_rd;
            wd3_d = dec_imm;
          end
          if (dec_kind == KindNop) begin
            done_d = 1'b1;
          end
        end
      end
      StExec: begin
        result_d   = bus.ULAResult;
        result_z_d = bus.Flag_z;
        result_c_d = bus.CarryOut;
        we3_d      = 1'b1;
        wa3_d      = dec_rd;
        wd3_d      = bus.ULAResult;
        state_d    = StWb;
      end
      StWb: begin
        if (dec_kind == KindLoadi) begin
          result_d = dec_imm;
        end
        done_d  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef DPCTRL_STICKY_CARRY_EN
    if ((state_q == StExec) && bus.CarryOut) begin
      sticky_d = 1'b1;
    end
    // A NOP clears the flag as it enters DONE, so it reads 0 during that cycle.
    if ((state_q == StIdle) && accept && (dec_kind == KindNop)) begin
      sticky_d = 1'b0;
    end
`else
    sticky_d = 1'b0;
`endif

    instr_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      instr_q       <= '0;
      instr_ready_q <= 1'b0;
      wd3_q         <= '0;
      wa3_q         <= '0;
      we3_q         <= 1'b0;
      ra1_q         <= '0;
      ra2_q         <= '0;
      ula_ctrl_q    <= '0;
      select_src_q  <= 1'b0;
      constante_q   <= '0;
      result_q      <= '0;
      result_z_q    <= 1'b0;
      result_c_q    <= 1'b0;
      done_q        <= 1'b0;
      sticky_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_ready_q <= instr_ready_d;
      wd3_q         <= wd3_d;
      wa3_q         <= wa3_d;
      we3_q         <= we3_d;
      ra1_q         <= ra1_d;
      ra2_q         <= ra2_d;
      ula_ctrl_q    <= ula_ctrl_d;
      select_src_q  <= select_src_d;
      constante_q   <= constante_d;
      result_q      <= result_d;
      result_z_q    <= result_z_d;
      result_c_q    <= result_c_d;
      done_q        <= done_d;
      sticky_q      <= sticky_d;
    end
  end

  assign bus.instr_ready  = instr_ready_q;
  assign bus.wd3          = wd3_q;
  assign bus.wa3          = wa3_q;
  assign bus.we3          = we3_q;
  assign bus.ra1          = ra1_q;
  assign bus.ra2          = ra2_q;
  assign bus.ULAControl   = ula_ctrl_q;
  assign bus.select_src   = select_src_q;
  assign bus.constante    = constante_q;
  assign bus.result       = result_q;
  assign bus.result_z     = result_z_q;
  assign bus.result_c     = result_c_q;
  assign bus.done         = done_q;
  assign bus.sticky_carry = sticky_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed, table-driven bench for datapath_ctrl; the bench plays instruction source
// and datapath, returning fixed ULA results per vector.
module tb_datapath_ctrl;

`ifdef DPCTRL_STICKY_CARRY_EN
  localparam bit StickyEn = 1'b1;
`else
  localparam bit StickyEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  datapath_ctrl_if #(.DataWidth(8)) bus ();

  datapath_ctrl #(
    .DataWidth(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] instr;
    logic [7:0]  ula;
    logic        fz;
    logic        fc;
    int          lat;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic [2:0]  op;
    logic        sel;
    logic [7:0]  cst;
    logic [2:0]  wa;
    logic [7:0]  wd;
    logic [7:0]  res;
    logic        rz;
    logic        rc;
    logic        sticky;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [21:0] mk(input logic [1:0] kind, input logic [7:0] imm,
                                     input logic [2:0] rs2, input logic [2:0] rs1,
                                     input logic [2:0] rd, input logic [2:0] op);
    return {imm, kind, rs2, rs1, rd, op};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int         n;
    int         we_n;
    int         we_cnt;
    int         done_n;
    logic [2:0] wa;
    logic [7:0] wd;
    @(negedge clk);
    bus.instr       = v.instr;
    bus.instr_valid = 1'b1;
    bus.ULAResult   = v.ula;
    bus.Flag_z      = v.fz;
    bus.CarryOut    = v.fc;
    n = 0;
    while (!bus.instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d_ready", idx), 32'(bus.instr_ready), 32'd1);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    we_n = 0; we_cnt = 0; done_n = 0; wa = '0; wd = '0;
    for (int c = 1; c <= 6 && done_n == 0; c++) begin
      @(negedge clk);
      check($sformatf("v%0d_busy_c%0d", idx, c), 32'(bus.instr_ready), 32'd0);
      if (c == 1 && v.lat == 3) begin
        check($sformatf("v%0d_ra1", idx), 32'(bus.ra1), 32'(v.ra1));
        check($sformatf("v%0d_ra2", idx), 32'(bus.ra2), 32'(v.ra2));
        check($sformatf("v%0d_ulactl", idx), 32'(bus.ULAControl), 32'(v.op));
        check($sformatf("v%0d_sel", idx), 32'(bus.select_src), 32'(v.sel));
        check($sformatf("v%0d_const", idx), 32'(bus.constante), 32'(v.cst));
      end
      if (bus.we3) begin
        we_cnt++;
        if (we_n == 0) begin
          we_n = c;
          wa = bus.wa3;
          wd = bus.wd3;
        end
      end
      if (bus.done) begin
        done_n = c;
        check($sformatf("v%0d_result", idx), 32'(bus.result), 32'(v.res));
        check($sformatf("v%0d_rz", idx), 32'(bus.result_z), 32'(v.rz));
        check($sformatf("v%0d_rc", idx), 32'(bus.result_c), 32'(v.rc));
        check($sformatf("v%0d_sticky", idx), 32'(bus.sticky_carry),
              32'(v.sticky & StickyEn));
      end
    end
    check($sformatf("v%0d_done_lat", idx), 32'(done_n), 32'(v.lat));
    check($sformatf("v%0d_we_cycle", idx), 32'(we_n), 32'(v.lat - 1));
    check($sformatf("v%0d_we_count", idx), 32'(we_cnt), (v.lat > 1) ? 32'd1 : 32'd0);
    if (v.lat > 1) begin
      check($sformatf("v%0d_wa3", idx), 32'(wa), 32'(v.wa));
      check($sformatf("v%0d_wd3", idx), 32'(wd), 32'(v.wd));
    end
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", idx), 32'(bus.done), 32'd0);
    check($sformatf("v%0d_ready_after", idx), 32'(bus.instr_ready), 32'd1);
  endtask

  initial begin
    int          acc_cnt;
    int          done_cnt;
    int          we_cnt;
    int          last_acc;
    int          bidx;
    logic        ready_seen;
    logic [11:0] wa_seq;
    logic [21:0] b2b[4];
    int          n;

    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.ULAResult   = '0;
    bus.Flag_z      = 1'b0;
    bus.CarryOut    = 1'b0;

    //             instr                      ula    fz    fc  lat ra1   ra2   op    sel   cst
    //             wa    wd     res    rz    rc    sticky
    vecs[0] = '{mk(2'b10, 8'h05, 3'd0, 3'd0, 3'd1, 3'd0), 8'hEE, 1'b1, 1'b1, 2, 3'd0, 3'd0, 3'd0,
                1'b0, 8'h00, 3'd1, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{mk(2'b10, 8'h03, 3'd0, 3'd0, 3'd2, 3'd0), 8'hEE, 1'b1, 1'b1, 2, 3'd0, 3'd0, 3'd0,
                1'b0, 8'h00, 3'd2, 8'h03, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{mk(2'b00, 8'h00, 3'd2, 3'd1, 3'd3, 3'd0), 8'h08, 1'b0, 1'b0, 3, 3'd1, 3'd2, 3'd0,
                1'b0, 8'h00, 3'd3, 8'h08, 8'h08, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{mk(2'b01, 8'h05, 3'd0, 3'd1, 3'd4, 3'd1), 8'h00, 1'b1, 1'b0, 3, 3'd1, 3'd0, 3'd1,
                1'b1, 8'h05, 3'd4, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{mk(2'b00, 8'h00, 3'd7, 3'd6, 3'd5, 3'd0), 8'h00, 1'b1, 1'b1, 3, 3'd6, 3'd7, 3'd0,
                1'b0, 8'h00, 3'd5, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{mk(2'b10, 8'hAA, 3'd0, 3'd0, 3'd6, 3'd0), 8'h12, 1'b0, 1'b0, 2, 3'd0, 3'd0, 3'd0,
                1'b0, 8'h00, 3'd6, 8'hAA, 8'hAA, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{mk(2'b11, 8'h00, 3'd0, 3'd0, 3'd0, 3'd0), 8'h33, 1'b0, 1'b0, 1, 3'd0, 3'd0, 3'd0,
                1'b0, 8'h00, 3'd0, 8'h00, 8'hAA, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{mk(2'b01, 8'h7F, 3'd0, 3'd3, 3'd7, 3'd2), 8'h55, 1'b0, 1'b0, 3, 3'd3, 3'd0, 3'd2,
                1'b1, 8'h7F, 3'd7, 8'h55, 8'h55, 1'b0, 1'b0, 1'b0};

    // Reset state.
    #12;
    check("rst_ready", 32'(bus.instr_ready), 32'd0);
    check("rst_we3", 32'(bus.we3), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_outs", 32'({bus.wd3, bus.wa3, bus.ra1, bus.ra2, bus.ULAControl}), 32'd0);
    check("rst_sticky", 32'(bus.sticky_carry), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(bus.instr_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

    // Back-to-back with instr_valid held high.
    for (int i = 0; i < 4; i++) begin
      b2b[i] = mk(2'b00, 8'h00, 3'd0, 3'd0, 3'(i + 1), 3'd0);
    end
    @(negedge clk);
    bus.instr = b2b[0];
    bus.instr_valid = 1'b1;
    bus.ULAResult = 8'h11;
    bus.Flag_z = 1'b0;
    bus.CarryOut = 1'b0;
    acc_cnt = 0; done_cnt = 0; we_cnt = 0; last_acc = -1; bidx = 0; wa_seq = '0;
    for (int c = 0; c < 24; c++) begin
      ready_seen = bus.instr_ready;
      if (bus.we3) begin
        we_cnt++;
        wa_seq = {wa_seq[8:0], bus.wa3};
      end
      if (bus.done) done_cnt++;
      if (ready_seen && bus.instr_valid) begin
        acc_cnt++;
        if (last_acc >= 0) check($sformatf("b2b_gap%0d", acc_cnt), 32'(c - last_acc), 32'd4);
        last_acc = c;
      end
      @(posedge clk);
      #1;
      if (ready_seen && bus.instr_valid) begin
        bidx++;
        if (bidx < 4) bus.instr = b2b[bidx];
        else bus.instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b_accepts", 32'(acc_cnt), 32'd4);
    check("b2b_done_cnt", 32'(done_cnt), 32'd4);
    check("b2b_we_cnt", 32'(we_cnt), 32'd4);
    check("b2b_wa_seq", 32'(wa_seq), 32'({3'd1, 3'd2, 3'd3, 3'd4}));

    // Reset asserted while in WB aborts the write.
    bus.instr = mk(2'b00, 8'h00, 3'd2, 3'd1, 3'd3, 3'd0);
    bus.ULAResult = 8'h99;
    bus.CarryOut = 1'b1;
    bus.instr_valid = 1'b1;
    n = 0;
    while (!bus.instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rwb_in_wb", 32'(bus.we3), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rwb_we3_drop", 32'(bus.we3), 32'd0);
    check("rwb_result", 32'(bus.result), 32'd0);
    check("rwb_flags", 32'({bus.result_z, bus.result_c, bus.sticky_carry}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    we_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.we3) we_cnt++;
      if (bus.done) done_cnt++;
    end
    check("rwb_no_write", 32'(we_cnt), 32'd0);
    check("rwb_no_done", 32'(done_cnt), 32'd0);
    check("rwb_idle_ready", 32'(bus.instr_ready), 32'd1);
    check("rwb_result_after", 32'(bus.result), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
